// File: rtl/uart_flit_assembler.sv
// Packs the UART receive byte stream into 128-bit flits, validates checksum and
// flit type, and presents good flits to the RX buffer over a valid/ready port.
module uart_flit_assembler #(
  parameter int FLIT_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit CHECK_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  out_valid,
  output logic [FLIT_WIDTH-1:0] out_flit,
  input  logic                  out_ready,
  output logic                  err_overflow,
  output logic                  err_checksum,
  output logic                  err_timeout,
  output logic [7:0]            drop_count
);

  localparam int NUM_BYTES = FLIT_WIDTH / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_idx;
  logic [TMO_W-1:0]        r_tmo;
  logic [FLIT_WIDTH-1:0]   r_shift;
  logic [15:0]             r_sum;
  logic                    r_out_valid;
  logic [FLIT_WIDTH-1:0]   r_out_flit;
  logic                    r_err_ovf;
  logic                    r_err_cks;
  logic                    r_err_tmo;
  logic [7:0]              r_drop_count;

  logic [FLIT_WIDTH-1:0]   w_flit;
  logic [15:0]             w_sum_next;
  logic [3:0]              w_type;
  logic                    w_complete;
  logic                    w_timeout;
  logic                    w_flit_ok;
  logic                    w_accept;
  logic                    w_load;
  logic                    w_pop;
  logic                    w_ovf;
  logic                    w_cks;
  logic                    w_drop;

  // Bytes shift in from the bottom, so byte 0 ends up in the top byte lane.
  assign w_flit     = {r_shift[FLIT_WIDTH-9:0], rx_data};
  // Even-indexed bytes are the high half of a 16-bit word, odd ones the low half.
  assign w_sum_next = r_sum + (r_idx[0] ? {8'h00, rx_data} : {rx_data, 8'h00});
  assign w_type     = w_flit[FLIT_WIDTH-5 -: 4];

  assign w_complete = (r_state == ST_COLLECT) && rx_valid &&
                      (r_idx == IDX_W'(NUM_BYTES - 1));
  assign w_timeout  = (r_state == ST_COLLECT) && !rx_valid &&
                      (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_flit_ok  = !CHECK_EN || ((w_sum_next == 16'h0000) && (w_type <= 4'd2));
  assign w_pop      = r_out_valid && out_ready;
  assign w_accept   = w_complete && w_flit_ok;
  assign w_load     = w_accept && (!r_out_valid || out_ready);
  assign w_ovf      = w_accept && r_out_valid && !out_ready;
  assign w_cks      = w_complete && !w_flit_ok;
  assign w_drop     = w_ovf || w_cks || w_timeout;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (rx_valid) w_state_next = ST_COLLECT;
      ST_COLLECT: if (w_complete || w_timeout) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_tmo   <= '0;
      r_shift <= '0;
      r_sum   <= '0;
    end else if (rx_valid) begin
      r_shift <= w_flit;
      r_tmo   <= '0;
      if (w_complete) begin
        r_idx <= '0;
        r_sum <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
        r_sum <= w_sum_next;
      end
    end else if (r_state == ST_COLLECT) begin
      if (w_timeout) begin
        r_idx <= '0;
        r_sum <= '0;
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_flit   <= '0;
      r_err_ovf    <= 1'b0;
      r_err_cks    <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_err_ovf <= w_ovf;
      r_err_cks <= w_cks;
      r_err_tmo <= w_timeout;
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      // A load in the same cycle as a pop replaces the outgoing flit seamlessly.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_flit  <= w_flit;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_flit     = r_out_flit;
  assign err_overflow = r_err_ovf;
  assign err_checksum = r_err_cks;
  assign err_timeout  = r_err_tmo;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_uart_flit_assembler.sv
// Self-checking bench for uart_flit_assembler: table-driven flit vectors plus
// hand-written backpressure, pop/load, timeout and reset sequences.
module tb_uart_flit_assembler;

  localparam int T         = 20;
  localparam int NUM_BYTES = 16;
  localparam int NV        = 7;

  localparam logic [127:0] F_GOOD  = 128'h1005_0001_0002_0000_0000_0000_0000_EFF8;
  localparam logic [127:0] F_BADCK = 128'h1005_0001_0002_0000_0000_0000_0000_EFF9;
  localparam logic [127:0] F_TYPE3 = 128'h1305_0001_0002_0000_0000_0000_0000_ECF8;
  localparam logic [127:0] F_BODY  = 128'h11AA_1234_5678_9ABC_DEF0_0000_0000_0BFE;
  localparam logic [127:0] F_TAIL  = 128'hF2FF_FFFF_0000_0000_0000_0000_0000_0D02;
  localparam logic [127:0] F_ZERO  = 128'h0;
  localparam logic [127:0] F_TYPEF = 128'h0F00_0000_0000_0000_0000_0000_0000_F100;

  typedef struct {
    string        name;
    logic [127:0] flit;
    logic         exp_good;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         out_ready;

  logic         c_out_valid, n_out_valid;
  logic [127:0] c_out_flit, n_out_flit;
  logic         c_err_ovf, c_err_cks, c_err_tmo;
  logic         n_err_ovf, n_err_cks, n_err_tmo;
  logic [7:0]   c_drop, n_drop;

  int           total = 0;
  int           bad = 0;
  int           n_ovf = 0;
  int           n_cks = 0;
  int           n_tmo = 0;
  int           exp_drop_c = 0;
  int           exp_drop_n = 0;
  logic [127:0] q_chk[$];
  logic [127:0] q_nc[$];
  vec_t         vecs[NV];

  uart_flit_assembler #(.FLIT_WIDTH(128), .TIMEOUT_CYCLES(T), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .out_valid(c_out_valid), .out_flit(c_out_flit), .out_ready(out_ready),
    .err_overflow(c_err_ovf), .err_checksum(c_err_cks), .err_timeout(c_err_tmo),
    .drop_count(c_drop)
  );

  uart_flit_assembler #(.FLIT_WIDTH(128), .TIMEOUT_CYCLES(T), .CHECK_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .out_valid(n_out_valid), .out_flit(n_out_flit), .out_ready(out_ready),
    .err_overflow(n_err_ovf), .err_checksum(n_err_cks), .err_timeout(n_err_tmo),
    .drop_count(n_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    check(name, 128'(act), 128'(exp));
  endtask

  task automatic send_bytes(input logic [127:0] f, input int first, input int last,
                            input bit ready_last);
    for (int i = first; i <= last; i++) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = f[127-8*i -: 8];
      if (ready_last && i == NUM_BYTES - 1) out_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected flit.
  logic         prev_hold_c;
  logic [127:0] prev_flit_c;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold_c = 1'b0;
    end else begin
      if (c_err_ovf) n_ovf++;
      if (c_err_cks) n_cks++;
      if (c_err_tmo) n_tmo++;
      if (prev_hold_c) check("hold_stable", c_out_flit, prev_flit_c);
      prev_hold_c = c_out_valid && !out_ready;
      prev_flit_c = c_out_flit;
      if (c_out_valid && out_ready) begin
        if (q_chk.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_chk: got flit %h expected none", c_out_flit);
        end else begin
          check("sb_chk", c_out_flit, q_chk.pop_front());
        end
      end
      if (n_out_valid && out_ready) begin
        if (q_nc.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_nc: got flit %h expected none", n_out_flit);
        end else begin
          check("sb_nc", n_out_flit, q_nc.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_tmo;
    int base;

    vecs[0] = '{"good_head",  F_GOOD,  1'b1};
    vecs[1] = '{"bad_cks",    F_BADCK, 1'b0};
    vecs[2] = '{"type3",      F_TYPE3, 1'b0};
    vecs[3] = '{"good_body",  F_BODY,  1'b1};
    vecs[4] = '{"good_tail",  F_TAIL,  1'b1};
    vecs[5] = '{"all_zero",   F_ZERO,  1'b1};
    vecs[6] = '{"typef",      F_TYPEF, 1'b0};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    #13;
    check_b("rst_valid", c_out_valid, 1'b0);
    check("rst_flit", c_out_flit, 128'h0);
    check("rst_errs", 128'({c_err_ovf, c_err_cks, c_err_tmo}), 128'h0);
    check_n("rst_drop", int'(c_drop), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < NV; i++) begin
      out_ready = 1'b1;
      if (vecs[i].exp_good) q_chk.push_back(vecs[i].flit);
      q_nc.push_back(vecs[i].flit);
      send_bytes(vecs[i].flit, 0, NUM_BYTES - 1, 1'b0);
      idle(1);
      check_b({vecs[i].name, "_valid"}, c_out_valid, vecs[i].exp_good);
      check_b({vecs[i].name, "_errcks"}, c_err_cks, !vecs[i].exp_good);
      if (vecs[i].exp_good) check({vecs[i].name, "_flit"}, c_out_flit, vecs[i].flit);
      check_b({vecs[i].name, "_nc_valid"}, n_out_valid, 1'b1);
      check({vecs[i].name, "_nc_flit"}, n_out_flit, vecs[i].flit);
      check_b({vecs[i].name, "_nc_errcks"}, n_err_cks, 1'b0);
      if (!vecs[i].exp_good) exp_drop_c++;
      check_n({vecs[i].name, "_drop"}, int'(c_drop), exp_drop_c);
      idle(2);
    end
    check_n("cks_pulses", n_cks, 3);

    // Backpressure: first flit held, second dropped as overflow.
    out_ready = 1'b0;
    q_chk.push_back(F_GOOD);
    q_nc.push_back(F_GOOD);
    send_bytes(F_GOOD, 0, NUM_BYTES - 1, 1'b0);
    idle(1);
    check_b("bp_held_valid", c_out_valid, 1'b1);
    send_bytes(F_BODY, 0, NUM_BYTES - 1, 1'b0);
    idle(1);
    exp_drop_c++;
    exp_drop_n++;
    check_b("bp_ovf", c_err_ovf, 1'b1);
    check_b("bp_nc_ovf", n_err_ovf, 1'b1);
    check_b("bp_no_cks", c_err_cks, 1'b0);
    check("bp_held_flit", c_out_flit, F_GOOD);
    check_n("bp_drop", int'(c_drop), exp_drop_c);
    check_n("bp_nc_drop", int'(n_drop), exp_drop_n);
    idle(1);
    check_b("bp_ovf_pulse_end", c_err_ovf, 1'b0);
    out_ready = 1'b1;
    idle(1);
    check_b("bp_pop_valid", c_out_valid, 1'b0);
    check_b("bp_nc_pop_valid", n_out_valid, 1'b0);
    check_n("ovf_pulses", n_ovf, 1);

    // Pop of the held flit in the same cycle the next flit completes.
    out_ready = 1'b0;
    q_chk.push_back(F_TAIL);
    q_nc.push_back(F_TAIL);
    send_bytes(F_TAIL, 0, NUM_BYTES - 1, 1'b0);
    idle(1);
    q_chk.push_back(F_BODY);
    q_nc.push_back(F_BODY);
    send_bytes(F_BODY, 0, NUM_BYTES - 1, 1'b1);
    idle(1);
    check_b("pl_valid", c_out_valid, 1'b1);
    check("pl_flit", c_out_flit, F_BODY);
    check_b("pl_no_ovf", c_err_ovf, 1'b0);
    check("pl_nc_flit", n_out_flit, F_BODY);
    check_n("pl_drop", int'(c_drop), exp_drop_c);
    idle(2);

    // Inter-byte timeout after 5 bytes.
    base = n_tmo;
    first_tmo = 0;
    send_bytes(F_GOOD, 0, 4, 1'b0);
    for (int j = 1; j <= T + 3; j++) begin
      idle(1);
      if (c_err_tmo && first_tmo == 0) first_tmo = j;
    end
    exp_drop_c++;
    exp_drop_n++;
    check_b("tmo_window", (first_tmo >= T) && (first_tmo <= T + 2), 1'b1);
    check_n("tmo_pulses", n_tmo - base, 1);
    check_n("tmo_drop", int'(c_drop), exp_drop_c);
    check_n("tmo_nc_drop", int'(n_drop), exp_drop_n);
    q_chk.push_back(F_GOOD);
    q_nc.push_back(F_GOOD);
    send_bytes(F_GOOD, 0, NUM_BYTES - 1, 1'b0);
    idle(1);
    check_b("tmo_next_valid", c_out_valid, 1'b1);
    check("tmo_next_flit", c_out_flit, F_GOOD);
    idle(2);

    // A byte landing exactly on the timeout cycle keeps the flit alive.
    base = n_tmo;
    q_chk.push_back(F_BODY);
    q_nc.push_back(F_BODY);
    send_bytes(F_BODY, 0, 4, 1'b0);
    idle(T - 1);
    send_bytes(F_BODY, 5, NUM_BYTES - 1, 1'b0);
    idle(1);
    check_b("edge_valid", c_out_valid, 1'b1);
    check("edge_flit", c_out_flit, F_BODY);
    check_n("edge_no_tmo", n_tmo - base, 0);
    check_n("edge_drop", int'(c_drop), exp_drop_c);
    idle(2);

    // Asynchronous reset with a held flit and a partial flit in progress.
    out_ready = 1'b0;
    send_bytes(F_GOOD, 0, NUM_BYTES - 1, 1'b0);
    idle(1);
    check_b("rr_held", c_out_valid, 1'b1);
    send_bytes(F_BODY, 0, 7, 1'b0);
    @(posedge clk);
    #3;
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_b("rr_valid", c_out_valid, 1'b0);
    check("rr_flit", c_out_flit, 128'h0);
    check_n("rr_drop", int'(c_drop), 0);
    check_n("rr_nc_drop", int'(n_drop), 0);
    check("rr_errs", 128'({c_err_ovf, c_err_cks, c_err_tmo}), 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    q_chk.push_back(F_TAIL);
    q_nc.push_back(F_TAIL);
    send_bytes(F_TAIL, 0, NUM_BYTES - 1, 1'b0);
    idle(1);
    check_b("rr_next_valid", c_out_valid, 1'b1);
    check("rr_next_flit", c_out_flit, F_TAIL);
    check_n("rr_next_drop", int'(c_drop), 0);
    idle(3);

    check_n("sb_chk_drained", q_chk.size(), 0);
    check_n("sb_nc_drained", q_nc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
